// File: rtl/vref_pkg.sv
// vref_pkg: shared vREF constants and types.
//   VrefCalibrationWidth : width of the vREF CAL trim code
//   VrefCalMid           : nominal mid-scale code (MSB set, rest clear)
//   vref_cal_state_e     : trim controller FSM states
package vref_pkg;

    localparam int VrefCalibrationWidth = 5;

    localparam logic [VrefCalibrationWidth-1:0] VrefCalMid =
        {1'b1, {(VrefCalibrationWidth-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } vref_cal_state_e;

endpackage

// File: rtl/vref_cal_ctrl.sv
// vref_cal_ctrl: successive-approximation trim controller for the vREF CAL pins.
// A start request runs a MSB-first binary search. Each trial code is held for
// SETTLE_CYCLES cycles, and then the comparator decides that bit. The final
// code is held on cal_o until the next request. Manual mode overrides the
// code and aborts any running search.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        one-cycle search request (idle/done only, manual off)
//   cmp_i          comparator: 1 = VOUT above target
//   manual_en_i    override enable; manual_cal_i is the override code
//   cal_o          registered CAL code
//   busy_o         search in progress
//   done_o         last search finished and result valid
//   sat_o          last result hit either end of the trim range
module vref_cal_ctrl
    import vref_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            cmp_i,
    input  logic                            manual_en_i,
    input  logic [VrefCalibrationWidth-1:0] manual_cal_i,
    output logic [VrefCalibrationWidth-1:0] cal_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            sat_o
);

    localparam int W  = VrefCalibrationWidth;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] CntReload = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IdxMsb    = IW'(W - 1);

    vref_cal_state_e state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  cal_q;      // doubles as the SAR trial register during SETTLE
    logic [W-1:0]  result_q;
    logic          done_q;
    logic          sat_q;

    logic          start_ok;
    logic          decide;
    logic [W-1:0]  code_dec;

    assign start_ok = start_i && !manual_en_i && (state_q != SETTLE);
    assign decide   = (state_q == SETTLE) && (cnt_q == '0);

    // Code after the current decision: bit idx is 1 during its trial, so the
    // decision simply writes !cmp_i; the next lower bit is then raised for
    // the following trial.
    always_comb begin
        code_dec        = cal_q;
        code_dec[idx_q] = !cmp_i;
        if (idx_q != '0) begin
            code_dec[idx_q - IW'(1)] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) state_d = SETTLE;
            end
            SETTLE: begin
                if (manual_en_i)                state_d = IDLE;
                else if (decide && idx_q == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy_o = (state_q == SETTLE);
    end

    // Counter, SAR register, result and status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            cal_q    <= VrefCalMid;
            result_q <= VrefCalMid;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else if (state_q == SETTLE) begin
            if (manual_en_i) begin
                // Abort: result_q keeps the last completed search.
                cal_q  <= manual_cal_i;
                done_q <= 1'b0;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                cal_q <= code_dec;
                if (idx_q != '0) begin
                    idx_q <= idx_q - IW'(1);
                    cnt_q <= CntReload;
                end else begin
                    result_q <= code_dec;
                    done_q   <= 1'b1;
                    sat_q    <= (code_dec == '0) || (code_dec == '1);
                end
            end
        end else if (start_ok) begin
            cal_q  <= VrefCalMid;
            idx_q  <= IdxMsb;
            cnt_q  <= CntReload;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cal_q <= manual_en_i ? manual_cal_i : result_q;
        end
    end

    assign cal_o  = cal_q;
    assign done_o = done_q;
    assign sat_o  = sat_q;

endmodule
